// File: rtl/wb_pkg.sv
// Shared widths and the queued write-back entry type for the writeback sequencer.
package wb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order queue of pending ALU write-backs; entries are also presented oldest-first
// (entries[0] is the head) with valid bits so the parent can search every pending value.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output wb_entry_t [DEPTH-1:0]  entries,
  output logic      [DEPTH-1:0]  entry_valid
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i]     = mem[rd_ptr + PTR_W'(i)];
      entry_valid[i] = ((PTR_W+1)'(i) < count);
    end
  end
endmodule

// File: rtl/writeback_sequencer.sv
// Register-file write port arbiter: loads first, then queued ALU results, then direct ALU.
// Define WB_BYPASS_EN to add rs/rt bypass lookup over all pending writes.
module writeback_sequencer
  import wb_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              write,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] wdata,
  output logic              busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic [DATA_W-1:0] fwd_rt_data
`endif
);
  logic                   q_full;
  logic                   q_empty;
  logic                   q_push;
  logic                   q_pop;
  wb_entry_t [QDEPTH-1:0] q_entries;
  logic      [QDEPTH-1:0] q_valid;

  logic      mem_take;
  logic      alu_take;
  logic      issue;
  wb_entry_t issue_entry;

  // Writes to r0 are dropped at the door so they never occupy a slot.
  assign mem_take  = mem_valid && (mem_rd != '0);
  assign alu_ready = !q_full && !reset;
  assign alu_take  = alu_valid && alu_ready && (alu_rd != '0);

  always_comb begin
    issue       = 1'b0;
    issue_entry = '0;
    q_pop       = 1'b0;
    q_push      = 1'b0;
    if (mem_take) begin
      issue       = 1'b1;
      issue_entry = '{rd: mem_rd, data: mem_data};
    end else if (!q_empty) begin
      issue       = 1'b1;
      issue_entry = q_entries[0];
      q_pop       = 1'b1;
    end else if (alu_take) begin
      issue       = 1'b1;
      issue_entry = '{rd: alu_rd, data: alu_data};
    end
    q_push = alu_take && !(!mem_take && q_empty);
  end

  wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (q_push),
    .push_entry  ('{rd: alu_rd, data: alu_data}),
    .pop         (q_pop),
    .full        (q_full),
    .empty       (q_empty),
    .entries     (q_entries),
    .entry_valid (q_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      write <= 1'b0;
      rd    <= '0;
      wdata <= '0;
    end else begin
      write <= issue;
      rd    <= issue_entry.rd;
      wdata <= issue_entry.data;
    end
  end

  assign busy = write || !q_empty;

`ifdef WB_BYPASS_EN
  logic [1:0][ADDR_W-1:0] fwd_addr;
  logic [1:0]             fwd_hit;
  logic [1:0][DATA_W-1:0] fwd_data;

  assign fwd_addr = {rt, rs};

  // Scan oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int p = 0; p < 2; p++) begin
      if (write && (rd == fwd_addr[p])) begin
        fwd_hit[p]  = 1'b1;
        fwd_data[p] = wdata;
      end
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_valid[i] && (q_entries[i].rd == fwd_addr[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = q_entries[i].data;
        end
      end
      if (fwd_addr[p] == '0) begin
        fwd_hit[p]  = 1'b0;
        fwd_data[p] = '0;
      end
    end
  end

  assign fwd_rs_hit  = fwd_hit[0];
  assign fwd_rt_hit  = fwd_hit[1];
  assign fwd_rs_data = fwd_data[0];
  assign fwd_rt_data = fwd_data[1];
`else
  logic unused_bypass;
  assign unused_bypass = ^{q_entries, q_valid};
`endif
endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed bench for writeback_sequencer: per-cycle vector table plus reset and bypass sequences.
module tb_writeback_sequencer;
  logic        clock;
  logic        reset;
  logic        alu_valid;
  logic [5:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [5:0]  mem_rd;
  logic [31:0] mem_data;
  logic        write;
  logic [5:0]  rd;
  logic [31:0] wdata;
  logic        busy;
`ifdef WB_BYPASS_EN
  logic [5:0]  rs;
  logic [5:0]  rt;
  logic        fwd_rs_hit;
  logic        fwd_rt_hit;
  logic [31:0] fwd_rs_data;
  logic [31:0] fwd_rt_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  writeback_sequencer #(.QDEPTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .write       (write),
    .rd          (rd),
    .wdata       (wdata),
    .busy        (busy)
`ifdef WB_BYPASS_EN
    ,
    .rs          (rs),
    .rt          (rt),
    .fwd_rs_hit  (fwd_rs_hit),
    .fwd_rt_hit  (fwd_rt_hit),
    .fwd_rs_data (fwd_rs_data),
    .fwd_rt_data (fwd_rt_data)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic        av;
    logic [5:0]  ard;
    logic [31:0] adat;
    logic        mv;
    logic [5:0]  mrd;
    logic [31:0] mdat;
    logic        er;
    logic        ew;
    logic [5:0]  erd;
    logic [31:0] ewd;
    logic        eb;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];

  function automatic vec_t mk(input int av, input int ard, input int adat,
                              input int mv, input int mrd, input int mdat,
                              input int er, input int ew, input int erd,
                              input int ewd, input int eb);
    vec_t v;
    v.av = 1'(av);  v.ard = 6'(ard);  v.adat = 32'(adat);
    v.mv = 1'(mv);  v.mrd = 6'(mrd);  v.mdat = 32'(mdat);
    v.er = 1'(er);  v.ew = 1'(ew);    v.erd = 6'(erd);
    v.ewd = 32'(ewd); v.eb = 1'(eb);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int av, input int ard, input int adat,
                       input int mv, input int mrd, input int mdat);
    alu_valid = 1'(av);
    alu_rd    = 6'(ard);
    alu_data  = 32'(adat);
    mem_valid = 1'(mv);
    mem_rd    = 6'(mrd);
    mem_data  = 32'(mdat);
  endtask

  initial begin
    // Idle ALU result goes straight through.
    vecs[0]  = mk(1, 5, 'h11, 0, 0, 0,     1, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0,        1, 1, 5, 'h11, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0);
    // Load and ALU collide: load first, ALU one cycle later.
    vecs[3]  = mk(1, 7, 'hBB, 1, 3, 'hAA,  1, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0,        1, 1, 3, 'hAA, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0,        1, 1, 7, 'hBB, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0);
    // Six cycles of loads starve the queue; the ALU offer holds until taken.
    vecs[7]  = mk(1, 10, 'h20, 1, 20, 'h40, 1, 0, 0, 0, 0);
    vecs[8]  = mk(1, 11, 'h21, 1, 21, 'h41, 1, 1, 20, 'h40, 1);
    vecs[9]  = mk(1, 12, 'h22, 1, 22, 'h42, 0, 1, 21, 'h41, 1);
    vecs[10] = mk(1, 12, 'h22, 1, 23, 'h43, 0, 1, 22, 'h42, 1);
    vecs[11] = mk(1, 12, 'h22, 1, 24, 'h44, 0, 1, 23, 'h43, 1);
    vecs[12] = mk(1, 12, 'h22, 1, 25, 'h45, 0, 1, 24, 'h44, 1);
    vecs[13] = mk(1, 12, 'h22, 0, 0, 0,     0, 1, 25, 'h45, 1);
    vecs[14] = mk(1, 12, 'h22, 0, 0, 0,     1, 1, 10, 'h20, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0,         1, 1, 11, 'h21, 1);
    vecs[16] = mk(0, 0, 0, 0, 0, 0,         1, 1, 12, 'h22, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0);
    // r0 ALU result is accepted and dropped.
    vecs[18] = mk(1, 0, 'hFF, 0, 0, 0,      1, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0);
    // r0 load takes no slot, so the ALU result goes direct.
    vecs[21] = mk(1, 8, 'h88, 1, 0, 'hEE,   1, 0, 0, 0, 0);
    vecs[22] = mk(0, 0, 0, 0, 0, 0,         1, 1, 8, 'h88, 1);
    // Back-to-back direct writes.
    vecs[23] = mk(1, 1, 'h1, 0, 0, 0,       1, 0, 0, 0, 0);
    vecs[24] = mk(1, 2, 'h2, 0, 0, 0,       1, 1, 1, 'h1, 1);
    vecs[25] = mk(0, 0, 0, 0, 0, 0,         1, 1, 2, 'h2, 1);
    vecs[26] = mk(0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
`ifdef WB_BYPASS_EN
    rs = '0;
    rt = '0;
`endif
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("reset_ready", 32'(alu_ready), 32'd0);
    chk("reset_write", 32'(write), 32'd0);
    chk("reset_rd", 32'(rd), 32'd0);
    chk("reset_wdata", wdata, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", 32'(alu_ready), 32'd1);

    for (int k = 0; k < NV; k++) begin
      @(negedge clock);
      drive(int'(vecs[k].av), int'(vecs[k].ard), int'(vecs[k].adat),
            int'(vecs[k].mv), int'(vecs[k].mrd), int'(vecs[k].mdat));
      #1;
      chk($sformatf("v%0d_ready", k), 32'(alu_ready), 32'(vecs[k].er));
      chk($sformatf("v%0d_write", k), 32'(write), 32'(vecs[k].ew));
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].eb));
      if (vecs[k].ew) begin
        chk($sformatf("v%0d_rd", k), 32'(rd), 32'(vecs[k].erd));
        chk($sformatf("v%0d_wdata", k), wdata, vecs[k].ewd);
      end
    end

    // Reset with two queued ALU results discards them.
    @(negedge clock);
    drive(1, 13, 'h30, 1, 4, 'h50);
    #1;
    chk("rq_ready0", 32'(alu_ready), 32'd1);
    @(negedge clock);
    drive(1, 14, 'h31, 1, 4, 'h51);
    #1;
    chk("rq_ready1", 32'(alu_ready), 32'd1);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("rq_ready_in_reset", 32'(alu_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rq_write_after", 32'(write), 32'd0);
    chk("rq_busy_after", 32'(busy), 32'd0);
    chk("rq_ready_after", 32'(alu_ready), 32'd1);
    @(negedge clock);
    #1;
    chk("rq_write_next", 32'(write), 32'd0);
    chk("rq_busy_next", 32'(busy), 32'd0);

`ifdef WB_BYPASS_EN
    // Queue r9 twice behind loads, then probe the bypass.
    @(negedge clock);
    drive(1, 9, 'h1, 1, 20, 'h40);
    @(negedge clock);
    drive(1, 9, 'h2, 1, 21, 'h41);
    @(negedge clock);
    drive(0, 0, 0, 1, 22, 'h42);
    rs = 6'd9;
    rt = 6'd0;
    #1;
    chk("byp_rs_hit", 32'(fwd_rs_hit), 32'd1);
    chk("byp_rs_data", fwd_rs_data, 32'h2);
    chk("byp_rt0_hit", 32'(fwd_rt_hit), 32'd0);
    rt = 6'd21;
    #1;
    chk("byp_rt_out_hit", 32'(fwd_rt_hit), 32'd1);
    chk("byp_rt_out_data", fwd_rt_data, 32'h41);
    rt = 6'd30;
    #1;
    chk("byp_rt_miss", 32'(fwd_rt_hit), 32'd0);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0);
    rs = '0;
    rt = '0;
    for (int k = 0; k < 4; k++) @(negedge clock);
    #1;
    chk("byp_drained_busy", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
